// File: rtl/tdc_pkg.sv
// Shared definitions for the hit time-stamper: FSM states, default widths
// and the event record layout {start stamp, width}.
package tdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_t;

    localparam int COARSE_W_DEF = 16;
    localparam int WIDTH_W_DEF  = 12;

    // Width sits in the LSBs; the start stamp sits directly above it.
    localparam int WIDTH_LSB = 0;

    function automatic int start_lsb(input int width_w);
        return WIDTH_LSB + width_w;
    endfunction

endpackage

// File: rtl/tdc_fifo.sv
// First-word-fall-through event FIFO; an extra pointer bit separates full from empty.
module tdc_fifo #(
    parameter int DW    = 28,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, do_pop, do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    assign valid = !empty;
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hit_stamp.sv
// Pulse time-stamper: coarse counter, rise/fall FSM and width counter feeding tdc_fifo.
// Optional HIT_STAMP_WIDTH_SAT_EN makes the width counter saturate and flag oSat.
module hit_stamp
    import tdc_pkg::*;
#(
    parameter int COARSE_W = COARSE_W_DEF,
    parameter int WIDTH_W  = WIDTH_W_DEF,
    parameter int DEPTH    = 4
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iRise,
    input  logic                      iFall,
    output logic [COARSE_W+WIDTH_W-1:0] oData,
    output logic                      oValid,
    input  logic                      iReady,
    output logic                      oSat,
    output logic [7:0]                oDrop,
    output logic                      oErr
);

    localparam int DW = COARSE_W + WIDTH_W;

    state_t              state;
    logic [COARSE_W-1:0] cnt, start;
    logic [WIDTH_W-1:0]  wid, wid_nxt, ev_w;
    logic [DW-1:0]       ev_data;
    logic                push, pop, full, drop, viol;

`ifdef HIT_STAMP_WIDTH_SAT_EN
    localparam logic [WIDTH_W-1:0] WMAX = '1;
    localparam int FW = DW + 1;
    logic at_max, ev_sat;

    assign at_max  = (wid == WMAX);
    assign wid_nxt = at_max ? wid : wid + WIDTH_W'(1);
    // wid lags the true width by one; reaching WMAX-1 already means the count is full.
    assign ev_w    = at_max ? WMAX : wid + WIDTH_W'(1);
    assign ev_sat  = (wid >= WMAX - WIDTH_W'(1));
`else
    localparam int FW = DW;

    assign wid_nxt = wid + WIDTH_W'(1);
    assign ev_w    = wid + WIDTH_W'(1);
`endif

    logic [FW-1:0] fifo_din, fifo_dout;

    always_comb begin
        ev_data = '0;
        ev_data[start_lsb(WIDTH_W) +: COARSE_W] = start;
        ev_data[WIDTH_LSB +: WIDTH_W]           = ev_w;
    end

`ifdef HIT_STAMP_WIDTH_SAT_EN
    assign fifo_din = {ev_sat, ev_data};
    assign oData    = fifo_dout[DW-1:0];
    assign oSat     = fifo_dout[DW];
`else
    assign fifo_din = ev_data;
    assign oData    = fifo_dout;
    assign oSat     = 1'b0;
`endif

    assign push = (state == HIGH) && iFall && !iRise;
    assign pop  = oValid && iReady;
    assign drop = push && full && !pop;
    assign viol = iRise && (iFall || state == HIGH);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) cnt <= '0;
        else       cnt <= cnt + COARSE_W'(1);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
            start <= '0;
            wid   <= '0;
            oErr  <= 1'b0;
        end else begin
            oErr <= viol;
            case (state)
                IDLE: begin
                    if (iRise && !iFall) begin
                        start <= cnt;
                        wid   <= '0;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    // A second rise abandons the open event and measures from here.
                    if (iRise && !iFall) begin
                        start <= cnt;
                        wid   <= '0;
                    end else if (iFall && !iRise) begin
                        state <= IDLE;
                    end else begin
                        wid <= wid_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)                     oDrop <= '0;
        else if (drop && oDrop != '1) oDrop <= oDrop + 8'd1;
    end

    tdc_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (oValid),
        .full  (full)
    );

endmodule

// File: tb/tb_hit_stamp.sv
// Directed bench for hit_stamp: nominal, protocol errors, full FIFO, wrap, saturation, reset.
module tb_hit_stamp;

    localparam int CW    = 16;
    localparam int WW    = 12;
    localparam int DEPTH = 4;

    logic           iClk = 1'b0, iRst = 1'b0, iRise = 1'b0, iFall = 1'b0, iReady = 1'b0;
    logic [CW+WW-1:0] oData;
    logic           oValid, oSat, oErr;
    logic [7:0]     oDrop;
    logic [15:0]    tcnt;
    int             checks = 0, errors = 0;

    hit_stamp #(.COARSE_W(CW), .WIDTH_W(WW), .DEPTH(DEPTH)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iRise  (iRise),
        .iFall  (iFall),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady),
        .oSat   (oSat),
        .oDrop  (oDrop),
        .oErr   (oErr)
    );

    always #5 iClk = ~iClk;

    // Free-running time reference: value seen at the next rising-edge sample.
    always @(posedge iClk or negedge iRst) begin
        if (!iRst) tcnt <= '0;
        else       tcnt <= tcnt + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [15:0] s, input logic [11:0] w);
        return {4'd0, s, w};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic pulse(input logic r, input logic f);
        iRise = r;
        iFall = f;
        tick(1);
        iRise = 1'b0;
        iFall = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] v);
        int n = 0;
        while (tcnt != v && n < 70000) begin
            tick(1);
            n++;
        end
        chk("wait_cnt_timeout", (tcnt == v), 1);
    endtask

    logic [31:0] q[$];
    logic [15:0] s;

    initial begin
        // reset state
        #3;
        chk("rst_valid", oValid, 0);
        chk("rst_data",  oData,  0);
        chk("rst_sat",   oSat,   0);
        chk("rst_drop",  oDrop,  0);
        chk("rst_err",   oErr,   0);
        @(posedge iClk);
        #1 iRst = 1'b1;

        // nominal pulse: rise at 100, fall 7 cycles later
        iReady = 1'b1;
        wait_cnt(16'd100);
        pulse(1, 0);
        tick(6);
        pulse(0, 1);
        chk("nom_valid", oValid, 1);
        chk("nom_data",  oData,  ev(16'd100, 12'd7));
        chk("nom_sat",   oSat,   0);
        tick(1);
        chk("nom_popped", oValid, 0);

        // rise, rise 3 later, fall 4 after that
        pulse(1, 0);
        tick(2);
        s = tcnt;
        pulse(1, 0);
        chk("rr_err", oErr, 1);
        tick(3);
        pulse(0, 1);
        chk("rr_err_once", oErr, 0);
        chk("rr_valid", oValid, 1);
        chk("rr_data",  oData,  ev(s, 12'd4));
        tick(1);
        chk("rr_single", oValid, 0);

        // simultaneous rise and fall, then a lone fall in IDLE
        pulse(1, 1);
        chk("rf_err",   oErr,   1);
        chk("rf_noev",  oValid, 0);
        tick(1);
        pulse(0, 1);
        chk("fall_idle_err",  oErr,   0);
        chk("fall_idle_noev", oValid, 0);

        // DEPTH+2 pulses with consumer stalled
        iReady = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            s = tcnt;
            pulse(1, 0);
            tick(1);
            pulse(0, 1);
            tick(1);
            if (i < DEPTH) q.push_back(ev(s, 12'd2));
        end
        chk("full_drop",  oDrop,  2);
        chk("full_valid", oValid, 1);
        chk("full_head",  oData,  q[0]);
        tick(1);
        chk("full_hold",  oData,  q[0]);
        // push and pop together while full
        s = tcnt;
        pulse(1, 0);
        iFall = 1'b1;
        iReady = 1'b1;
        tick(1);
        iFall = 1'b0;
        void'(q.pop_front());
        q.push_back(ev(s, 12'd1));
        chk("full_pp_drop", oDrop, 2);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain", oData, q.pop_front());
            tick(1);
        end
        chk("drain_empty", oValid, 0);

        // push and pop together with one entry held
        iReady = 1'b0;
        s = tcnt;
        pulse(1, 0);
        pulse(0, 1);
        chk("one_head", oData, ev(s, 12'd1));
        s = tcnt;
        pulse(1, 0);
        iFall = 1'b1;
        iReady = 1'b1;
        tick(1);
        iFall = 1'b0;
        chk("one_pp_valid", oValid, 1);
        chk("one_pp_head",  oData,  ev(s, 12'd1));
        tick(1);
        chk("one_pp_empty", oValid, 0);

        // 5000-cycle pulse
        s = tcnt;
        pulse(1, 0);
        tick(4999);
        pulse(0, 1);
        chk("sat_valid", oValid, 1);
`ifdef HIT_STAMP_WIDTH_SAT_EN
        chk("sat_data", oData, ev(s, 12'd4095));
        chk("sat_flag", oSat,  1);
`else
        chk("sat_data", oData, ev(s, 12'd904));
        chk("sat_flag", oSat,  0);
`endif
        tick(1);

        // reset while HIGH with two entries queued
        iReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pulse(1, 0);
            pulse(0, 1);
        end
        pulse(1, 0);
        tick(2);
        chk("pre_rst_valid", oValid, 1);
        #2 iRst = 1'b0;
        #1;
        chk("mid_rst_valid", oValid, 0);
        chk("mid_rst_data",  oData,  0);
        chk("mid_rst_drop",  oDrop,  0);
        @(posedge iClk);
        #1 iRst = 1'b1;
        pulse(0, 1);
        chk("post_rst_fall_valid", oValid, 0);
        chk("post_rst_fall_err",   oErr,   0);
        tick(1);
        chk("post_rst_noev", oValid, 0);

        // coarse counter wrap during the pulse
        iReady = 1'b1;
        wait_cnt(16'd65533);
        pulse(1, 0);
        tick(4);
        pulse(0, 1);
        chk("wrap_valid", oValid, 1);
        chk("wrap_data",  oData,  ev(16'd65533, 12'd5));
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_stamp.md
HIT_STAMP -- requirements
Module: hit_stamp

Interface
REQ-001 Parameter COARSE_W, 16, width of the free-running coarse time counter.
REQ-002 Parameter WIDTH_W, 12, width of the measured pulse-width field.
REQ-003 Parameter DEPTH, 4, event FIFO depth in entries (power of two, at least 2).
REQ-004 iClk  in  1  sole clock; all logic is on its rising edge.
REQ-005 iRst  in  1  asynchronous reset, active low.
REQ-006 iRise  in  1  single-cycle rising-edge pulse from the upstream edge detector.
REQ-007 iFall  in  1  single-cycle falling-edge pulse from the upstream edge detector.
REQ-008 oData  out  COARSE_W+WIDTH_W  FIFO head as {start stamp, width}; width occupies the LSBs.
REQ-009 oValid  out  1  oData holds a valid event.
REQ-010 iReady  in  1  consumer accepts oData in any cycle where oValid and iReady are both high.
REQ-011 oSat  out  1  head event's width saturated (sideband, travels with oData).
REQ-012 oDrop  out  8  saturating count of events lost because the FIFO was full.
REQ-013 oErr  out  1  one-cycle pulse on a protocol violation (see REQ-018 and REQ-019).

Function
REQ-014 Coarse counter: increments by 1 every cycle and wraps modulo 2^COARSE_W.
REQ-015 FSM state IDLE: iRise alone latches the counter value as the start stamp, clears the width counter, and moves to HIGH.
REQ-016 FSM state HIGH: the width counter increments each cycle.
- iFall alone pushes {start, width} and returns the FSM to IDLE.
- width = (fall-sample cycle) - (rise-sample cycle); rise at t, fall at t+5 gives width 5.
REQ-017 iFall in IDLE is ignored, with no error.
REQ-018 iRise in HIGH restarts the measurement with a new start stamp, discards the open event, and pulses oErr.
REQ-019 iRise and iFall in the same cycle are ignored with no state change, and oErr pulses.
REQ-020 Push latency: the event is visible on oData/oValid on the cycle after the iFall sample.
REQ-021 FIFO is first-word-fall-through.
- Pop occurs when oValid and iReady are both high.
- oData and oSat hold stable while oValid is high and iReady is low.
REQ-022 Push while full with no pop in the same cycle drops the new event; oDrop increments and saturates at 255.
REQ-023 Push and pop in the same cycle while full: both take effect; nothing is dropped and occupancy is unchanged.
REQ-024 Push and pop in the same cycle while holding one entry: the new event becomes the head on the next cycle.
REQ-025 FIFO read and write pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.

Reset
REQ-026 Reset assertion clears all state immediately, regardless of iClk: FSM to IDLE, counters to 0, FIFO empty.
REQ-027 Reset values: oValid=0, oData=0, oSat=0, oDrop=0, oErr=0.
REQ-028 Reset asserted mid-pulse in HIGH discards the open event; after release, a fall with no preceding rise is ignored.

Configuration
REQ-029 With HIT_STAMP_WIDTH_SAT_EN defined, the width counter stops at 2^WIDTH_W-1 and the pushed event carries oSat=1.
REQ-030 Without HIT_STAMP_WIDTH_SAT_EN, the width wraps modulo 2^WIDTH_W, oSat is tied to 0, and no saturation logic is present.

Structure
REQ-031 A shared package tdc_pkg holds:
- the FSM state enumeration (IDLE, HIGH);
- default COARSE_W and WIDTH_W constants;
- the event record layout: field offsets for start and width.
REQ-032 The FIFO is a sub-module, tdc_fifo, parameterised by data width and DEPTH; the FSM and counters stay in hit_stamp.

Verification
REQ-033 Scenario, nominal pulse: rise at counter 100, fall 7 cycles later with iReady=1 -> next cycle oValid=1, oData={100,7}, oSat=0.
REQ-034 Scenario, full FIFO: DEPTH+2 pulses with iReady=0 -> DEPTH entries held, oDrop=2, entries drain in order once iReady=1.
REQ-035 Scenario, wrap-around: rise at counter 65533, fall 5 cycles later -> start stamp=65533 and width=5, despite the coarse counter wrapping.
REQ-036 Scenario, protocol violations:
- rise, rise 3 cycles later, fall 4 cycles after that -> one event, width 4, one oErr pulse;
- simultaneous iRise and iFall -> oErr pulse, no event.
REQ-037 Scenario, saturation: pulse of 5000 cycles with WIDTH_W=12.
- With HIT_STAMP_WIDTH_SAT_EN -> width=4095, oSat=1.
- Without it -> width=904, oSat=0.
REQ-038 Scenario, reset mid-operation: iRst low during HIGH with 2 entries queued -> oValid=0 immediately; after release, a fall with no rise produces no event.
